// File: rtl/lfsr_bank_if.sv
// Output stream of lfsr_bank: one word per handshake, tagged with its channel and a period-wrap flag.
interface lfsr_bank_if #(
  parameter int WIDTH = 16,
  parameter int CH_W  = 2
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_wrap;

  modport master (output out_valid, out_data, out_ch, out_wrap, input out_ready);
  modport slave  (input out_valid, out_data, out_ch, out_wrap, output out_ready);
endinterface

// File: rtl/lfsr_bank.sv
// Bank of NUM_CH independent Galois LFSRs, served round-robin on one valid/ready stream.
// Per-channel seeding with zero-seed guard and a wrap flag when a channel returns to its start value.
//
// state | meaning
// IDLE  | stream off, out_valid=0, outputs read 0, seed loads accepted
// RUN   | out_valid=1, word for channel ptr presented, advances on handshake
module lfsr_bank #(
  parameter int               WIDTH  = 16,
  parameter int               NUM_CH = 4,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(16'hB400),
  localparam int              CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [WIDTH-1:0] seed,
  output logic             load_ignored,
  lfsr_bank_if.master      out_if
);

  // Arrays are sized to the full index range so every ptr/load_ch value is a legal index.
  localparam int              NSLOT   = 1 << CH_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_LIM = (CH_W + 1)'(NUM_CH);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state [NSLOT];
  logic [WIDTH-1:0] start [NSLOT];
  logic             moved [NSLOT];
  logic [CH_W-1:0]  ptr;

  logic [CH_W-1:0]  ptr_inc;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] seed_fix;
  logic             load_ok;
  logic             load_hit;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_wrap;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input int c);
    logic [WIDTH-1:0] v;
    v = WIDTH'(c + 1);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  always_comb begin
    ptr_inc  = (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
    adv      = nxt(state[ptr]);
    seed_fix = (seed == '0) ? WIDTH'(1) : seed;
    load_ok  = load && (fsm == IDLE) && ({1'b0, load_ch} < NUM_LIM);
    load_hit = load_ok && (load_ch == ptr);
    // With a single channel the next word comes from the slot being advanced this edge.
    if (ptr_inc == ptr) begin
      nxt_data = adv;
      nxt_wrap = (adv == start[ptr]);
    end else begin
      nxt_data = state[ptr_inc];
      nxt_wrap = moved[ptr_inc] && (state[ptr_inc] == start[ptr_inc]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NSLOT; c++) begin
        state[c] <= init_val(c);
        start[c] <= init_val(c);
        moved[c] <= 1'b0;
      end
      ptr              <= '0;
      fsm              <= IDLE;
      load_ignored     <= 1'b0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_ch    <= '0;
      out_if.out_wrap  <= 1'b0;
    end else begin
      load_ignored <= load && !load_ok;
      if (load_ok) begin
        state[load_ch] <= seed_fix;
        start[load_ch] <= seed_fix;
        moved[load_ch] <= 1'b0;
      end
      case (fsm)
        IDLE: begin
          if (enable) begin
            fsm              <= RUN;
            out_if.out_valid <= 1'b1;
            out_if.out_ch    <= ptr;
            out_if.out_data  <= load_hit ? seed_fix : state[ptr];
            out_if.out_wrap  <= !load_hit && moved[ptr] && (state[ptr] == start[ptr]);
          end
        end
        RUN: begin
          if (out_if.out_ready) begin
            state[ptr] <= adv;
            moved[ptr] <= 1'b1;
            ptr        <= ptr_inc;
            if (enable) begin
              out_if.out_ch   <= ptr_inc;
              out_if.out_data <= nxt_data;
              out_if.out_wrap <= nxt_wrap;
            end else begin
              fsm              <= IDLE;
              out_if.out_valid <= 1'b0;
              out_if.out_ch    <= '0;
              out_if.out_data  <= '0;
              out_if.out_wrap  <= 1'b0;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: main 16-bit/4-channel instance against a behavioural model,
// plus a 4-bit/1-channel instance for period wrap and a 3-channel instance for channel range.
module tb_lfsr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: WIDTH=16, NUM_CH=4
  logic        rst0, en0, load0, ign0;
  logic [1:0]  lch0;
  logic [15:0] seed0;
  lfsr_bank_if #(.WIDTH(16), .CH_W(2)) if0 ();
  lfsr_bank #(.WIDTH(16), .NUM_CH(4), .TAPS(16'hB400)) u0 (
    .clk(clk), .reset(rst0), .enable(en0), .load(load0), .load_ch(lch0),
    .seed(seed0), .load_ignored(ign0), .out_if(if0));

  // Instance 1: WIDTH=4, NUM_CH=1, TAPS=C
  logic        rst1, en1, load1, ign1;
  logic [0:0]  lch1;
  logic [3:0]  seed1;
  lfsr_bank_if #(.WIDTH(4), .CH_W(1)) if1 ();
  lfsr_bank #(.WIDTH(4), .NUM_CH(1), .TAPS(4'hC)) u1 (
    .clk(clk), .reset(rst1), .enable(en1), .load(load1), .load_ch(lch1),
    .seed(seed1), .load_ignored(ign1), .out_if(if1));

  // Instance 2: WIDTH=16, NUM_CH=3
  logic        rst2, en2, load2, ign2;
  logic [1:0]  lch2;
  logic [15:0] seed2;
  lfsr_bank_if #(.WIDTH(16), .CH_W(2)) if2 ();
  lfsr_bank #(.WIDTH(16), .NUM_CH(3), .TAPS(16'hB400)) u2 (
    .clk(clk), .reset(rst2), .enable(en2), .load(load2), .load_ch(lch2),
    .seed(seed2), .load_ignored(ign2), .out_if(if2));

  // Behavioural model of instance 0
  int m_st[4], m_start[4];
  bit m_moved[4];
  int m_ptr;
  bit m_run, m_ign;

  function automatic int lfsr_next(input int s, input int taps);
    return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
  endfunction

  function automatic logic [20:0] exp0();
    logic [15:0] d;
    logic [1:0]  c;
    logic        w;
    d = m_run ? 16'(m_st[m_ptr]) : 16'h0;
    c = m_run ? 2'(m_ptr) : 2'd0;
    w = m_run && m_moved[m_ptr] && (m_st[m_ptr] == m_start[m_ptr]);
    return {m_run, c, d, w, m_ign};
  endfunction

  function automatic logic [20:0] got0();
    return {if0.out_valid, if0.out_ch, if0.out_data, if0.out_wrap, ign0};
  endfunction

  // Advance one clock; update the model from the inputs seen at that edge; settle.
  task automatic step();
    @(posedge clk);
    if (rst0) begin
      for (int c = 0; c < 4; c++) begin
        m_st[c] = c + 1; m_start[c] = c + 1; m_moved[c] = 1'b0;
      end
      m_ptr = 0; m_run = 1'b0; m_ign = 1'b0;
    end else begin
      m_ign = load0 && (m_run || int'(lch0) >= 4);
      if (load0 && !m_run && int'(lch0) < 4) begin
        m_st[lch0]    = (seed0 == 16'h0) ? 1 : int'(seed0);
        m_start[lch0] = m_st[lch0];
        m_moved[lch0] = 1'b0;
      end
      if (!m_run) m_run = en0;
      else if (if0.out_ready) begin
        m_st[m_ptr]    = lfsr_next(m_st[m_ptr], 'hB400);
        m_moved[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % 4;
        m_run          = en0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1; rst2 = 1;
    step(); step();
    if (got0() !== 21'h0) begin
      errors++; $display("FAIL reset0: got %h exp %h", got0(), 21'h0);
    end
    checks++;
    if ({if1.out_valid, if1.out_data, ign1, if2.out_valid, if2.out_data, ign2} !== 24'h0) begin
      errors++; $display("FAIL reset12: got v1=%b d1=%h v2=%b d2=%h", if1.out_valid, if1.out_data,
                         if2.out_valid, if2.out_data);
    end
    checks++;
    rst0 = 0;
  endtask

  task automatic test_basic();
    logic [17:0] tbl [8] = '{{2'd0,16'h0001}, {2'd1,16'h0002}, {2'd2,16'h0003}, {2'd3,16'h0004},
                             {2'd0,16'hB400}, {2'd1,16'h0001}, {2'd2,16'hB401}, {2'd3,16'h0002}};
    en0 = 1; if0.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b1, tbl[i]}) begin
        errors++; $display("FAIL basic_order[%0d]: got v=%b ch=%0d d=%h exp ch=%0d d=%h", i,
                           if0.out_valid, if0.out_ch, if0.out_data, tbl[i][17:16], tbl[i][15:0]);
      end
      checks++;
    end
    en0 = 0;
    step();
    if (got0() !== exp0()) begin
      errors++; $display("FAIL basic_stop: got %h exp %h", got0(), exp0());
    end
    checks++;
  endtask

  task automatic test_zero_seed();
    logic [17:0] tbl [5] = '{{2'd0,16'h002D}, {2'd1,16'h0002}, {2'd2,16'h0001},
                             {2'd3,16'h0004}, {2'd0,16'hB416}};
    rst0 = 1; step(); rst0 = 0;
    load0 = 1; lch0 = 2; seed0 = 16'h0000; step();
    lch0 = 0; seed0 = 16'h002D; step();
    load0 = 0; en0 = 1; if0.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({if0.out_ch, if0.out_data} !== tbl[i] || got0() !== exp0()) begin
        errors++; $display("FAIL zero_seed[%0d]: got ch=%0d d=%h exp ch=%0d d=%h", i,
                           if0.out_ch, if0.out_data, tbl[i][17:16], tbl[i][15:0]);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    en0 = 1; if0.out_ready = 1;
    step(); step();
    held = {2'(m_ptr), 16'(m_st[m_ptr])};
    if0.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b1, held} || got0() !== exp0()) begin
        errors++; $display("FAIL stall[%0d]: got v=%b ch=%0d d=%h exp ch=%0d d=%h", i,
                           if0.out_valid, if0.out_ch, if0.out_data, held[17:16], held[15:0]);
      end
      checks++;
    end
    if0.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (got0() !== exp0()) begin
        errors++; $display("FAIL resume[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
    end
  endtask

  task automatic test_load_in_run();
    load0 = 1; lch0 = 1; seed0 = 16'h1234;
    step();
    load0 = 0;
    if (ign0 !== 1'b1 || got0() !== exp0()) begin
      errors++; $display("FAIL load_run_pulse: got ign=%b all=%h exp ign=1 all=%h", ign0, got0(), exp0());
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (got0() !== exp0()) begin
        errors++; $display("FAIL load_run_seq[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
    end
  endtask

  task automatic test_enable_drop();
    en0 = 0; if0.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if0.out_valid !== 1'b1 || got0() !== exp0()) begin
        errors++; $display("FAIL drop_hold[%0d]: got v=%b all=%h exp v=1 all=%h", i,
                           if0.out_valid, got0(), exp0());
      end
      checks++;
    end
    if0.out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (if0.out_valid !== 1'b0 || got0() !== exp0()) begin
        errors++; $display("FAIL drop_idle[%0d]: got v=%b all=%h exp v=0 all=%h", i,
                           if0.out_valid, got0(), exp0());
      end
      checks++;
    end
  endtask

  task automatic test_reset_stall();
    en0 = 1; if0.out_ready = 1;
    step(); step(); step();
    if0.out_ready = 0;
    step(); step();
    rst0 = 1; step(); rst0 = 0;
    if (if0.out_valid !== 1'b0 || got0() !== exp0()) begin
      errors++; $display("FAIL reset_stall: got v=%b exp v=0", if0.out_valid);
    end
    checks++;
    if0.out_ready = 1;
    step();
    if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b1, 2'd0, 16'h0001}) begin
      errors++; $display("FAIL restart: got v=%b ch=%0d d=%h exp v=1 ch=0 d=0001",
                         if0.out_valid, if0.out_ch, if0.out_data);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst0          = ($urandom_range(63) == 0);
      en0           = ($urandom_range(3) != 0);
      if0.out_ready = ($urandom_range(2) != 0);
      load0         = ($urandom_range(7) == 0);
      lch0          = 2'($urandom_range(3));
      seed0         = ($urandom_range(5) == 0) ? 16'h0 : 16'($urandom);
      step();
      if (got0() !== exp0()) begin
        errors++; $display("FAIL random[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
    end
    rst0 = 0; load0 = 0; en0 = 0; if0.out_ready = 1;
    step(); step();
  endtask

  task automatic test_wrap();
    logic [3:0] seq [17] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC};
    rst1 = 0; load1 = 1; lch1 = 0; seed1 = 4'h1; en1 = 1; if1.out_ready = 1;
    step();
    load1 = 0;
    for (int i = 0; i < 17; i++) begin
      if ({if1.out_valid, if1.out_data, if1.out_wrap} !== {1'b1, seq[i], (i == 15)}) begin
        errors++; $display("FAIL wrap[%0d]: got v=%b d=%h w=%b exp d=%h w=%b", i,
                           if1.out_valid, if1.out_data, if1.out_wrap, seq[i], (i == 15));
      end
      checks++;
      step();
    end
    en1 = 0; step(); step();
  endtask

  task automatic test_ch_range();
    logic [17:0] tbl [4] = '{{2'd0,16'h0001}, {2'd1,16'h0001}, {2'd2,16'h0003}, {2'd0,16'hB400}};
    rst2 = 0; load2 = 1; lch2 = 3; seed2 = 16'h1234; en2 = 0; if2.out_ready = 1;
    step();
    if (ign2 !== 1'b1) begin
      errors++; $display("FAIL range_ign: got %b exp 1", ign2);
    end
    checks++;
    lch2 = 1; seed2 = 16'h0000;
    step();
    if (ign2 !== 1'b0) begin
      errors++; $display("FAIL range_ok: got %b exp 0", ign2);
    end
    checks++;
    load2 = 0; en2 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({if2.out_valid, if2.out_ch, if2.out_data} !== {1'b1, tbl[i]}) begin
        errors++; $display("FAIL range_seq[%0d]: got ch=%0d d=%h exp ch=%0d d=%h", i,
                           if2.out_ch, if2.out_data, tbl[i][17:16], tbl[i][15:0]);
      end
      checks++;
    end
    en2 = 0; step();
  endtask

  initial begin
    rst0 = 1; en0 = 0; load0 = 0; lch0 = 0; seed0 = 0; if0.out_ready = 0;
    rst1 = 1; en1 = 0; load1 = 0; lch1 = 0; seed1 = 0; if1.out_ready = 0;
    rst2 = 1; en2 = 0; load2 = 0; lch2 = 0; seed2 = 0; if2.out_ready = 0;
    test_reset();
    test_basic();
    test_zero_seed();
    test_backpressure();
    test_load_in_run();
    test_enable_drop();
    test_reset_stall();
    test_random();
    test_wrap();
    test_ch_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
